// File: rtl/instruction_decoder_if.sv
// Fetch/execute/redirect signal bundle around the instruction decoder.
// master = decoder side, slave = fetch/execute environment side.
interface instruction_decoder_if #(
  parameter int INST_W = 16,
  parameter int REG_AW = 3
);
  logic              read_inst;
  logic              inst_valid;
  logic [INST_W-1:0] instruction;
  logic              decoded_inst;
  logic              ex_valid;
  logic              ex_ready;
  logic [3:0]        opcode;
  logic [REG_AW-1:0] rd;
  logic [REG_AW-1:0] rs1;
  logic [REG_AW-1:0] rs2;
  logic [INST_W-1:0] imm;
  logic              br_done;
  logic              br_taken;
  logic              execute_branch;
  logic [INST_W-1:0] branch_offset;
  logic              jump_flag;
  logic [INST_W-5:0] offset_jump;
  logic              branch_ack;
  logic              illegal;
  logic [15:0]       stall_count;

  modport master (
    output read_inst, decoded_inst, ex_valid,
    output opcode, rd, rs1, rs2, imm,
    output execute_branch, branch_offset,
    output jump_flag, offset_jump,
    output illegal, stall_count,
    input  inst_valid, instruction, ex_ready,
    input  br_done, br_taken, branch_ack
  );

  modport slave (
    input  read_inst, decoded_inst, ex_valid,
    input  opcode, rd, rs1, rs2, imm,
    input  execute_branch, branch_offset,
    input  jump_flag, offset_jump,
    input  illegal, stall_count,
    output inst_valid, instruction, ex_ready,
    output br_done, br_taken, branch_ack
  );
endinterface

// File: rtl/instruction_decoder.sv
// Decode stage: fetch handshake, field split, issue, branch/jump redirect.
// Optional macro DECODE_STALL_CNT_EN enables the execute-stall counter.
module instruction_decoder #(
  parameter int INST_W = 16,
  parameter int REG_AW = 3,
  parameter int IMM_W  = 6
) (
  input  logic clk,
  input  logic reset,
  instruction_decoder_if.master bus
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_ISSUE,
    S_BR_WAIT,
    S_REDIRECT,
    S_HALT
  } state_e;

  localparam logic [3:0] OP_BEQ = 4'hB;
  localparam logic [3:0] OP_BNE = 4'hC;
  localparam logic [3:0] OP_JMP = 4'hD;

  state_e            state_q, state_d;
  logic [INST_W-1:0] instr_q, instr_d;
  logic              armed_q, armed_d;
  logic [3:0]        opcode_q, opcode_d;
  logic [REG_AW-1:0] rd_q, rd_d;
  logic [REG_AW-1:0] rs1_q, rs1_d;
  logic [REG_AW-1:0] rs2_q, rs2_d;
  logic [IMM_W-1:0]  imm_q, imm_d;
  logic              illegal_q, illegal_d;

  logic              read_inst;
  logic              decoded;
  logic              ex_valid;
  logic              exec_br;
  logic              jump;
  logic [3:0]        dec_op;
  logic              is_br;
  logic              is_bad;

  assign dec_op = instr_q[INST_W-1 -: 4];
  assign is_br  = (opcode_q == OP_BEQ) || (opcode_q == OP_BNE);
  assign is_bad = (dec_op == 4'hA) || (dec_op == 4'hE) || (dec_op == 4'hF);

  always_comb begin
    state_d   = state_q;
    instr_d   = instr_q;
    // a new word is accepted only after valid has been seen low
    armed_d   = armed_q | ~bus.inst_valid;
    opcode_d  = opcode_q;
    rd_d      = rd_q;
    rs1_d     = rs1_q;
    rs2_d     = rs2_q;
    imm_d     = imm_q;
    illegal_d = illegal_q;
    read_inst = 1'b0;
    decoded   = 1'b0;
    ex_valid  = 1'b0;
    exec_br   = 1'b0;
    jump      = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        read_inst = ~bus.inst_valid & ~reset;
        if (bus.inst_valid && armed_q) begin
          instr_d = bus.instruction;
          armed_d = 1'b0;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        decoded  = 1'b1;
        opcode_d = dec_op;
        rd_d     = instr_q[INST_W-5 -: REG_AW];
        rs1_d    = instr_q[INST_W-5-REG_AW -: REG_AW];
        rs2_d    = instr_q[INST_W-5-2*REG_AW -: REG_AW];
        imm_d    = instr_q[IMM_W-1:0];
        if (dec_op == OP_JMP) begin
          state_d = S_REDIRECT;
        end else if (is_bad) begin
          illegal_d = 1'b1;
          state_d   = S_HALT;
        end else begin
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        ex_valid = 1'b1;
        if (bus.ex_ready) state_d = is_br ? S_BR_WAIT : S_FETCH;
      end
      S_BR_WAIT: begin
        if (bus.br_done) state_d = bus.br_taken ? S_REDIRECT : S_FETCH;
      end
      S_REDIRECT: begin
        jump    = (opcode_q == OP_JMP);
        exec_br = (opcode_q != OP_JMP);
        if (bus.branch_ack) state_d = S_FETCH;
      end
      S_HALT: ;
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      instr_q   <= '0;
      armed_q   <= 1'b1;
      opcode_q  <= '0;
      rd_q      <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      imm_q     <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      instr_q   <= instr_d;
      armed_q   <= armed_d;
      opcode_q  <= opcode_d;
      rd_q      <= rd_d;
      rs1_q     <= rs1_d;
      rs2_q     <= rs2_d;
      imm_q     <= imm_d;
      illegal_q <= illegal_d;
    end
  end

  logic [INST_W-1:0] imm_ext;
  assign imm_ext = {{(INST_W-IMM_W){imm_q[IMM_W-1]}}, imm_q};

  assign bus.read_inst      = read_inst;
  assign bus.decoded_inst   = decoded;
  assign bus.ex_valid       = ex_valid;
  assign bus.opcode         = opcode_q;
  assign bus.rd             = rd_q;
  assign bus.rs1            = rs1_q;
  assign bus.rs2            = rs2_q;
  assign bus.imm            = imm_ext;
  assign bus.execute_branch = exec_br;
  assign bus.branch_offset  = exec_br ? imm_ext : '0;
  assign bus.jump_flag      = jump;
  assign bus.offset_jump    = jump ? instr_q[INST_W-5:0] : '0;
  assign bus.illegal        = illegal_q;

`ifdef DECODE_STALL_CNT_EN
  logic [15:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (state_q == S_ISSUE && !bus.ex_ready && stall_q != 16'hFFFF)
      stall_d = stall_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) stall_q <= '0;
    else       stall_q <= stall_d;
  end

  assign bus.stall_count = stall_q;
`else
  assign bus.stall_count = '0;
`endif

endmodule

// File: tb/tb_instruction_decoder.sv
// Directed bench for instruction_decoder.
module tb_instruction_decoder;

  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  instruction_decoder_if #(.INST_W(16), .REG_AW(3)) bus ();

  instruction_decoder #(
    .INST_W(16),
    .REG_AW(3),
    .IMM_W(6)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.master)
  );

`ifdef DECODE_STALL_CNT_EN
  localparam logic [15:0] EXP_STALL = 16'd5;
`else
  localparam logic [15:0] EXP_STALL = 16'd0;
`endif

  task automatic cy();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset                = 1'b1;
    bus.inst_valid       = 1'b0;
    bus.instruction      = '0;
    bus.ex_ready         = 1'b0;
    bus.br_done          = 1'b0;
    bus.br_taken         = 1'b0;
    bus.branch_ack       = 1'b0;
    cy();
    cy();
    chk("rst_read", bus.read_inst, 0);
    chk("rst_exv", bus.ex_valid, 0);
    chk("rst_ill", bus.illegal, 0);
    chk("rst_stall", bus.stall_count, 0);
    chk("rst_op", bus.opcode, 0);
    reset = 1'b0;
    #1;
    chk("fetch_read", bus.read_inst, 1);

    // ADD rd=3 rs1=1 rs2=2
    bus.inst_valid  = 1'b1;
    bus.instruction = 16'h2650;
    #1;
    chk("read_drop", bus.read_inst, 0);
    cy();
    chk("add_dec", bus.decoded_inst, 1);
    chk("add_exv0", bus.ex_valid, 0);
    bus.inst_valid = 1'b0;
    cy();
    chk("add_dec_pulse", bus.decoded_inst, 0);
    chk("add_exv", bus.ex_valid, 1);
    chk("add_op", bus.opcode, 4'h2);
    chk("add_rd", bus.rd, 3);
    chk("add_rs1", bus.rs1, 1);
    chk("add_rs2", bus.rs2, 2);
    repeat (5) cy();
    chk("stall_exv", bus.ex_valid, 1);
    chk("stall_rd", bus.rd, 3);
    chk("stall_rs2", bus.rs2, 2);
    chk("stall_cnt", bus.stall_count, EXP_STALL);
    bus.ex_ready = 1'b1;
    cy();
    bus.ex_ready = 1'b0;
    chk("add_done_exv", bus.ex_valid, 0);
    chk("add_done_read", bus.read_inst, 1);

    // BEQ taken, imm = -2
    bus.inst_valid  = 1'b1;
    bus.instruction = 16'hB0BE;
    cy();
    bus.inst_valid = 1'b0;
    cy();
    chk("beq_exv", bus.ex_valid, 1);
    chk("beq_op", bus.opcode, 4'hB);
    chk("beq_imm", bus.imm, 16'hFFFE);
    bus.ex_ready = 1'b1;
    cy();
    bus.ex_ready = 1'b0;
    chk("bw_exv", bus.ex_valid, 0);
    chk("bw_read", bus.read_inst, 0);
    chk("bw_exbr", bus.execute_branch, 0);
    cy();
    chk("bw_hold", bus.read_inst, 0);
    bus.br_done  = 1'b1;
    bus.br_taken = 1'b1;
    cy();
    bus.br_done  = 1'b0;
    bus.br_taken = 1'b0;
    chk("br_c1", bus.execute_branch, 1);
    chk("br_off", bus.branch_offset, 16'hFFFE);
    chk("br_jmp", bus.jump_flag, 0);
    cy();
    chk("br_c2", bus.execute_branch, 1);
    bus.branch_ack = 1'b1;
    #1;
    chk("br_c3", bus.execute_branch, 1);
    cy();
    bus.branch_ack = 1'b0;
    chk("br_clr", bus.execute_branch, 0);
    chk("br_off_clr", bus.branch_offset, 0);
    chk("br_read", bus.read_inst, 1);

    // BNE not taken
    bus.inst_valid  = 1'b1;
    bus.instruction = 16'hC0C1;
    cy();
    bus.inst_valid = 1'b0;
    cy();
    chk("bne_exv", bus.ex_valid, 1);
    bus.ex_ready = 1'b1;
    cy();
    bus.ex_ready = 1'b0;
    bus.br_done  = 1'b1;
    bus.br_taken = 1'b0;
    cy();
    bus.br_done = 1'b0;
    chk("bne_exbr", bus.execute_branch, 0);
    chk("bne_read", bus.read_inst, 1);

    // JMP with valid held high throughout
    bus.inst_valid  = 1'b1;
    bus.instruction = 16'hD123;
    cy();
    chk("jmp_dec", bus.decoded_inst, 1);
    cy();
    chk("jmp_flag", bus.jump_flag, 1);
    chk("jmp_off", bus.offset_jump, 12'h123);
    chk("jmp_exv", bus.ex_valid, 0);
    chk("jmp_exbr", bus.execute_branch, 0);
    cy();
    chk("jmp_hold", bus.jump_flag, 1);
    chk("jmp_exv2", bus.ex_valid, 0);
    bus.branch_ack = 1'b1;
    cy();
    bus.branch_ack = 1'b0;
    chk("jmp_clr", bus.jump_flag, 0);
    chk("jmp_off_clr", bus.offset_jump, 0);
    chk("stuck_read", bus.read_inst, 0);
    cy();
    chk("no_relatch", bus.decoded_inst, 0);
    bus.inst_valid = 1'b0;
    #1;
    chk("relatch_read", bus.read_inst, 1);
    cy();

    // illegal opcode
    bus.inst_valid  = 1'b1;
    bus.instruction = 16'hE000;
    cy();
    bus.inst_valid = 1'b0;
    cy();
    chk("ill_set", bus.illegal, 1);
    chk("ill_read", bus.read_inst, 0);
    chk("ill_exv", bus.ex_valid, 0);
    cy();
    cy();
    chk("halt_read", bus.read_inst, 0);
    chk("halt_sticky", bus.illegal, 1);

    // reset out of HALT, then reset mid-redirect
    reset = 1'b1;
    cy();
    reset = 1'b0;
    #1;
    chk("rst_ill_clr", bus.illegal, 0);
    chk("rst_read2", bus.read_inst, 1);
    bus.inst_valid  = 1'b1;
    bus.instruction = 16'hD0FF;
    cy();
    bus.inst_valid = 1'b0;
    cy();
    chk("jmp2_flag", bus.jump_flag, 1);
    reset = 1'b1;
    cy();
    chk("rr_jmp", bus.jump_flag, 0);
    chk("rr_off", bus.offset_jump, 0);
    chk("rr_read", bus.read_inst, 0);
    chk("rr_op", bus.opcode, 0);
    chk("rr_ill", bus.illegal, 0);
    reset = 1'b0;
    cy();
    chk("rr_fetch", bus.read_inst, 1);
    chk("rr_exbr", bus.execute_branch, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
